pwm_capture: RTL and testbench

- Input-capture counterpart of the PWM generator. It measures the period and high time of an external PWM waveform arriving on one io_in pad.
- Each completed cycle is presented as a result on a valid/ready stream. The Wishbone register block or the logic-analyzer path consumes these results.
- It sits inside the user project beside the PWM generator and shares the Wishbone clock.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_capture_if.sv | 22 ++
 rtl/pwm_sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 124 ++++++++++++
 tb/tb_pwm_capture.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared FSM state type and parameter defaults for the PWM input-capture block.
package pwm_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE      = 2'd0,
      CAP_ARM       = 2'd1,
      CAP_MEAS_HIGH = 2'd2,
      CAP_MEAS_LOW  = 2'd3
   } pwm_cap_state_t;

   localparam int unsigned CAP_CNT_W_DEF = 24;
   localparam int unsigned CAP_SYNC_DEF  = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Result stream of the PWM capture block: valid/ready plus period, high time and timeout flag.
interface pwm_capture_if import pwm_pkg::*; #(
   parameter int unsigned CNT_W = CAP_CNT_W_DEF
) ();

   logic             res_valid_o;
   logic             res_ready_i;
   logic [CNT_W-1:0] res_period_o;
   logic [CNT_W-1:0] res_high_o;
   logic             res_timeout_o;

   modport master (
      output res_valid_o, res_period_o, res_high_o, res_timeout_o,
      input  res_ready_i
   );

   modport slave (
      input  res_valid_o, res_period_o, res_high_o, res_timeout_o,
      output res_ready_i
   );

endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM pad input and produces single-cycle rise/fall pulses.
module pwm_sync_edge import pwm_pkg::*; #(
   parameter int unsigned SYNC_STAGES = CAP_SYNC_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_dly  <= w_sync;
      end
   end

   assign o_rise = w_sync & ~r_dly;
   assign o_fall = ~w_sync & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM waveform and streams one result per cycle.
module pwm_capture import pwm_pkg::*; #(
   parameter int unsigned CNT_W       = CAP_CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = CAP_SYNC_DEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          en_i,
   input  logic          pwm_i,
   input  logic          clear_i,
   pwm_capture_if.master res,
   output logic          overrun_o,
   output logic          busy_o
);

   localparam logic [1:0] S_IDLE      = CAP_IDLE;
   localparam logic [1:0] S_ARM       = CAP_ARM;
   localparam logic [1:0] S_MEAS_HIGH = CAP_MEAS_HIGH;
   localparam logic [1:0] S_MEAS_LOW  = CAP_MEAS_LOW;
   // Counter value at which cnt+1 would reach all-ones.
   localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);

   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CNT_W-1:0] r_high_cap, w_hcap_nxt;
   logic             r_valid, r_timeout, r_overrun;
   logic [CNT_W-1:0] r_period, r_high;
   logic             w_load, w_ld_timeout;
   logic [CNT_W-1:0] w_ld_period, w_ld_high;
   logic             w_rise, w_fall;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_async (pwm_i),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hcap_nxt   = r_high_cap;
      w_load       = 1'b0;
      w_ld_period  = '1;
      w_ld_high    = '1;
      w_ld_timeout = 1'b0;
      if (!en_i) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_hcap_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_ARM;
            S_ARM: begin
               if (w_rise) begin
                  w_state_nxt = S_MEAS_HIGH;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_cnt_nxt = w_cnt_inc;
               // Saturation outranks any edge seen in the same cycle.
               if (r_cnt == CNT_LAST) begin
                  w_load       = 1'b1;
                  w_ld_timeout = 1'b1;
                  w_ld_high    = (r_state == S_MEAS_HIGH) ? '1 : r_high_cap;
                  w_state_nxt  = S_ARM;
                  w_cnt_nxt    = '0;
               end else if (r_state == S_MEAS_HIGH && w_fall) begin
                  w_hcap_nxt  = w_cnt_inc;
                  w_state_nxt = S_MEAS_LOW;
               end else if (r_state == S_MEAS_LOW && w_rise) begin
                  w_load      = 1'b1;
                  w_ld_period = w_cnt_inc;
                  w_ld_high   = r_high_cap;
                  w_state_nxt = S_MEAS_HIGH;
                  w_cnt_nxt   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_high_cap <= '0;
         r_valid    <= 1'b0;
         r_period   <= '0;
         r_high     <= '0;
         r_timeout  <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_high_cap <= w_hcap_nxt;
         if (w_load) begin
            r_valid   <= 1'b1;
            r_period  <= w_ld_period;
            r_high    <= w_ld_high;
            r_timeout <= w_ld_timeout;
         end else if (r_valid && res.res_ready_i) begin
            r_valid <= 1'b0;
         end
         if (w_load && r_valid && !res.res_ready_i) begin
            r_overrun <= 1'b1;
         end else if (clear_i) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign res.res_valid_o   = r_valid;
   assign res.res_period_o  = r_period;
   assign res.res_high_o    = r_high;
   assign res.res_timeout_o = r_timeout;
   assign overrun_o         = r_overrun;
   assign busy_o            = (r_state == S_MEAS_HIGH) || (r_state == S_MEAS_LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table vectors, random waveforms and multi-cycle corner cases.
module tb_pwm_capture;

   localparam int unsigned CNT_W = 8;

   typedef struct {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
      logic             timeout;
   } res_t;

   typedef struct {
      int unsigned      hi;
      int unsigned      lo;
      int unsigned      reps;
      logic [CNT_W-1:0] exp_period;
      logic [CNT_W-1:0] exp_high;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic pwm   = 1'b0;
   logic clr   = 1'b0;
   logic overrun, busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_q[$];
   res_t pend;
   bit   have_prev = 1'b0;
   vec_t tbl[6];

   pwm_capture_if #(.CNT_W(CNT_W)) res_if ();

   pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .en_i      (en),
      .pwm_i     (pwm),
      .clear_i   (clr),
      .res       (res_if),
      .overrun_o (overrun),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted transfer must match the oldest expected result.
   always begin
      @(negedge clk);
      #3;
      if (res_if.res_valid_o && res_if.res_ready_i) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got period=%0d high=%0d timeout=%0b, required no result",
                     res_if.res_period_o, res_if.res_high_o, res_if.res_timeout_o);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            if (res_if.res_period_o !== e.period || res_if.res_high_o !== e.high ||
                res_if.res_timeout_o !== e.timeout) begin
               n_fail++;
               $display("FAIL result: got period=%0d high=%0d timeout=%0b, required period=%0d high=%0d timeout=%0b",
                        res_if.res_period_o, res_if.res_high_o, res_if.res_timeout_o,
                        e.period, e.high, e.timeout);
            end
         end
      end
   end

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // One PWM cycle; its result is expected once the following rise arrives.
   task automatic run_cycle(input int unsigned h, input int unsigned l,
                            input logic [CNT_W-1:0] ep, input logic [CNT_W-1:0] eh);
      if (have_prev) exp_q.push_back(pend);
      pwm = 1'b1;
      cyc(h);
      pwm = 1'b0;
      cyc(l);
      pend      = '{ep, eh, 1'b0};
      have_prev = 1'b1;
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      check("drain_pending_results", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic close_seq();
      if (have_prev) exp_q.push_back(pend);
      have_prev = 1'b0;
      pwm = 1'b1;
      cyc(2);
      pwm = 1'b0;
      drain(20);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   res_if.res_valid_o,   0);
      check({tag, "_period"},  res_if.res_period_o,  0);
      check({tag, "_high"},    res_if.res_high_o,    0);
      check({tag, "_timeout"}, res_if.res_timeout_o, 0);
      check({tag, "_overrun"}, overrun,              0);
      check({tag, "_busy"},    busy,                 0);
   endtask

   initial begin
      int unsigned h, l;
      res_if.res_ready_i = 1'b1;

      tbl[0] = '{30,  70, 3, 100,  30};
      tbl[1] = '{5,    5, 3,  10,   5};
      tbl[2] = '{1,    1, 4,   2,   1};
      tbl[3] = '{1,  253, 1, 254,   1};
      tbl[4] = '{200, 54, 1, 254, 200};
      tbl[5] = '{12,   3, 2,  15,  12};

      // Reset state
      cyc(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // Table-driven waveforms, ready held high
      en = 1'b1;
      cyc(4);
      check("arm_not_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         for (int unsigned r = 0; r < tbl[i].reps; r++) begin
            run_cycle(tbl[i].hi, tbl[i].lo, tbl[i].exp_period, tbl[i].exp_high);
         end
      end
      check("table_no_overrun", overrun, 0);
      close_seq();
      en = 1'b0;
      cyc(2);

      // Random waveforms against the arithmetic model: period = high + low
      en = 1'b1;
      cyc(4);
      repeat (25) begin
         h = $urandom_range(1, 60);
         l = $urandom_range(1, 60);
         run_cycle(h, l, CNT_W'(h + l), CNT_W'(h));
      end
      close_seq();
      check("random_no_overrun", overrun, 0);
      en = 1'b0;
      cyc(2);

      // Saturation while high, then while low, then normal measurement
      en = 1'b1;
      cyc(4);
      exp_q.push_back('{8'hFF, 8'hFF, 1'b1});
      pwm = 1'b1;
      cyc(280);
      check("timeout_high_back_to_arm", busy, 0);
      cyc(20);
      pwm = 1'b0;
      cyc(10);
      drain(5);
      exp_q.push_back('{8'hFF, 8'd10, 1'b1});
      pwm = 1'b1;
      cyc(10);
      pwm = 1'b0;
      cyc(300);
      check("timeout_low_back_to_arm", busy, 0);
      drain(5);
      run_cycle(20, 30, 8'd50, 8'd20);
      close_seq();
      en = 1'b0;
      cyc(2);

      // Overrun with ready low, then clear
      en = 1'b1;
      cyc(4);
      res_if.res_ready_i = 1'b0;
      repeat (4) begin
         pwm = 1'b1;
         cyc(5);
         pwm = 1'b0;
         cyc(5);
      end
      check("overrun_set",         overrun,              1);
      check("overrun_valid",       res_if.res_valid_o,   1);
      check("overrun_last_period", res_if.res_period_o,  10);
      check("overrun_last_high",   res_if.res_high_o,    5);
      check("overrun_timeout",     res_if.res_timeout_o, 0);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("overrun_cleared",     overrun,              0);
      check("clear_keeps_valid",   res_if.res_valid_o,   1);
      en = 1'b0;
      cyc(1);
      exp_q.push_back('{8'd10, 8'd5, 1'b0});
      res_if.res_ready_i = 1'b1;
      drain(10);
      cyc(2);
      check("overrun_valid_dropped", res_if.res_valid_o, 0);

      // Enable raised mid-pulse: the partial cycle is not reported
      pwm = 1'b1;
      cyc(6);
      en = 1'b1;
      cyc(10);
      pwm = 1'b0;
      cyc(15);
      check("midpulse_fall_ignored", busy, 0);
      run_cycle(8, 12, 8'd20, 8'd8);
      close_seq();
      en = 1'b0;
      cyc(2);

      // Enable dropped in MEAS_LOW with a pending result
      en = 1'b1;
      cyc(4);
      res_if.res_ready_i = 1'b0;
      pwm = 1'b1; cyc(6);
      pwm = 1'b0; cyc(6);
      pwm = 1'b1; cyc(6);
      pwm = 1'b0; cyc(6);
      check("endrop_busy_before", busy,               1);
      check("endrop_valid_before", res_if.res_valid_o, 1);
      en = 1'b0;
      cyc(1);
      check("endrop_idle",   busy,                 0);
      check("endrop_valid",  res_if.res_valid_o,   1);
      check("endrop_period", res_if.res_period_o,  12);
      check("endrop_high",   res_if.res_high_o,    6);
      exp_q.push_back('{8'd12, 8'd6, 1'b0});
      res_if.res_ready_i = 1'b1;
      drain(10);
      cyc(2);
      check("endrop_accepted", res_if.res_valid_o, 0);

      // Reset mid-MEAS_HIGH with a pending result, then resume
      en = 1'b1;
      cyc(4);
      res_if.res_ready_i = 1'b0;
      pwm = 1'b1; cyc(4);
      pwm = 1'b0; cyc(4);
      pwm = 1'b1; cyc(6);
      check("prereset_valid", res_if.res_valid_o, 1);
      check("prereset_busy",  busy,               1);
      rst_n = 1'b0;
      pwm   = 1'b0;
      en    = 1'b0;
      cyc(1);
      check_all_zero("midreset");
      rst_n = 1'b1;
      res_if.res_ready_i = 1'b1;
      cyc(3);
      en = 1'b1;
      cyc(4);
      run_cycle(15, 25, 8'd40, 8'd15);
      run_cycle(7, 9, 8'd16, 8'd7);
      close_seq();
      en = 1'b0;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
